// File: rtl/ftb_update_queue_pkg.sv
// ============================================================================
// ftb_update_queue_pkg
// Frontend shared types: FTB entry info, update record and queue FSM states.
// Rev 1.0
// ============================================================================
`default_nettype none

package ftb_update_queue_pkg;

  localparam int XDEF = 32;

  typedef struct packed {
    logic            valid;
    logic [3:0]      br_offset;
    logic [XDEF-1:0] target;
    logic [1:0]      ctr;
  } ftbInfo_t;

  typedef struct packed {
    logic [XDEF-1:0] pc;
    ftbInfo_t        ftbInfo;
  } ftbUpdateRec_t;

  typedef enum logic [0:0] {
    idle = 1'b0,
    req  = 1'b1
  } ftbUpdQ_status_t;

endpackage

`default_nettype wire

// File: rtl/ftb_update_queue_if.sv
// ============================================================================
// ftb_update_queue_if
// Commit-side enqueue and FTB update handshake bundle.
// Rev 1.0
// ============================================================================
`default_nettype none

interface ftb_update_queue_if #(
  parameter int DEPTH = 4
);
  import ftb_update_queue_pkg::*;

  logic                       i_enq_vld;
  logic                       o_enq_rdy;
  logic [XDEF-1:0]            i_enq_pc;
  ftbInfo_t                   i_enq_ftbInfo;
  logic                       o_update_req;
  logic                       i_update_finished;
  logic [XDEF-1:0]            o_update_pc;
  ftbInfo_t                   o_update_ftbInfo;
  logic [$clog2(DEPTH+1)-1:0] o_count;
  logic [15:0]                o_drop_cnt;

  modport master (
    output i_enq_vld, i_enq_pc, i_enq_ftbInfo, i_update_finished,
    input  o_enq_rdy, o_update_req, o_update_pc, o_update_ftbInfo,
           o_count, o_drop_cnt
  );

  modport slave (
    input  i_enq_vld, i_enq_pc, i_enq_ftbInfo, i_update_finished,
    output o_enq_rdy, o_update_req, o_update_pc, o_update_ftbInfo,
           o_count, o_drop_cnt
  );

endinterface

`default_nettype wire

// File: rtl/ftb_update_fifo.sv
// ============================================================================
// ftb_update_fifo
// Circular record buffer with an overwrite port for the newest entry.
// Rev 1.0
// ============================================================================
`default_nettype none

module ftb_update_fifo
  import ftb_update_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            i_push,
  input  wire ftbUpdateRec_t   i_push_rec,
  input  wire logic            i_pop,
  input  wire logic            i_ovw,
  input  wire ftbInfo_t        i_ovw_info,
  output      ftbUpdateRec_t   o_head_rec,
  output      logic [XDEF-1:0] o_tail_prev_pc,
  output      logic [CW-1:0]   o_count
);

  ftbUpdateRec_t r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_tail_prev;

  assign w_tail_prev    = r_tail - PW'(1);
  assign o_head_rec     = r_mem[r_head];
  assign o_tail_prev_pc = r_mem[w_tail_prev].pc;
  assign o_count        = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_rec;
        r_tail        <= r_tail + PW'(1);
      end
      // Coalesce target is the newest entry; the caller guarantees it is never the head
      if (i_ovw) begin
        r_mem[w_tail_prev].ftbInfo <= i_ovw_info;
      end
      if (i_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ftb_update_queue.sv
// ============================================================================
// ftb_update_queue
// Commit-side FTB update requester: queues, coalesces and issues records.
// Rev 1.0
// ============================================================================
`default_nettype none

module ftb_update_queue
  import ftb_update_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input wire logic          clk,
  input wire logic          rst,
  ftb_update_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  ftbUpdQ_status_t r_state;
  ftbUpdQ_status_t w_state_nxt;
  logic [15:0]     r_drop_cnt;
  logic [CW-1:0]   w_count;
  logic [XDEF-1:0] w_tail_prev_pc;
  ftbUpdateRec_t   w_head_rec;
  ftbUpdateRec_t   w_push_rec;
  logic            w_pop;
  logic            w_rdy;
  logic            w_acc;
  logic            w_coal;
  logic            w_alloc;

  // The finished pulse frees a slot in the same cycle, so a full queue still accepts
  assign w_pop   = (r_state == req) && bus.i_update_finished;
  assign w_rdy   = (w_count != c_FULL) || w_pop;
  assign w_acc   = bus.i_enq_vld && w_rdy;
  assign w_coal  = w_acc && (w_count >= CW'(2)) && (bus.i_enq_pc == w_tail_prev_pc);
  assign w_alloc = w_acc && !w_coal;

  assign w_push_rec.pc      = bus.i_enq_pc;
  assign w_push_rec.ftbInfo = bus.i_enq_ftbInfo;

  ftb_update_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .i_push         (w_alloc),
    .i_push_rec     (w_push_rec),
    .i_pop          (w_pop),
    .i_ovw          (w_coal),
    .i_ovw_info     (bus.i_enq_ftbInfo),
    .o_head_rec     (w_head_rec),
    .o_tail_prev_pc (w_tail_prev_pc),
    .o_count        (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      idle: if (w_alloc) w_state_nxt = req;
      req:  if (w_pop && !w_alloc && (w_count == CW'(1))) w_state_nxt = idle;
      default: w_state_nxt = idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (bus.i_enq_vld && !w_rdy && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.o_enq_rdy        = w_rdy;
  assign bus.o_update_req     = (r_state == req);
  assign bus.o_update_pc      = w_head_rec.pc;
  assign bus.o_update_ftbInfo = w_head_rec.ftbInfo;
  assign bus.o_count          = w_count;
  assign bus.o_drop_cnt       = r_drop_cnt;

endmodule

`default_nettype wire

// File: doc/ftb_update_queue.md
# ftb_update_queue

Commit-side requester for the FTB update port. Buffers FTB training records (`pc`, `ftbInfo_t`) produced at branch commit and drives them one at a time into the FTB update handshake (`update_req` / `update_finished`). Holds each head record stable until the FTB signals completion. Merges back-to-back records for the same fetch-block PC and counts records dropped on overflow.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `i_enq_vld`  in  1  commit-side record valid.
- `o_enq_rdy`  out  1  record accepted this cycle if `i_enq_vld`.
- `i_enq_pc`  in  `XDEF`  fetch-block start PC of the record.
- `i_enq_ftbInfo`  in  `ftbInfo_t`  new FTB entry contents.
- `o_update_req`  out  1  to FTB `i_update_req`.
- `i_update_finished`  in  1  from FTB `o_update_finished`.
- `o_update_pc`  out  `XDEF`  to FTB `i_update_pc` (head PC).
- `o_update_ftbInfo`  out  `ftbInfo_t`  to FTB `i_update_ftbInfo` (head info).
- `o_count`  out  `$clog2(DEPTH+1)`  occupied entries.
- `o_drop_cnt`  out  16  saturating count of rejected records.

## Operation
- Storage: circular buffer with `DEPTH` entries {pc, ftbInfo}, plus `head`/`tail` pointers of `$clog2(DEPTH)` bits (natural wrap) and `count`.
- FSM states:
  - IDLE (count==0): `o_update_req`=0.
  - REQ (count≥1): `o_update_req`=1, outputs = entry[head].
- FSM transitions:
  - IDLE→REQ when count becomes nonzero.
  - REQ→IDLE when the pop empties the queue.
  - REQ→REQ otherwise.
- Pop: in REQ with `i_update_finished`=1, `head`+1 at the end of that cycle. The head entry must not change during any REQ cycle, including the finished cycle, because the FTB samples info in the finished cycle.
- Accept rule: `o_enq_rdy` = (count != DEPTH) || (state==REQ && `i_update_finished`). Combinational from `i_update_finished` (a registered FTB output).
- Accepted enqueue:
  - Coalesce: if count≥2 and `i_enq_pc` == entry[tail-1].pc, overwrite entry[tail-1].ftbInfo; count is unchanged.
  - Otherwise write entry[tail], `tail`+1, count+1.
  - Never coalesce into the head entry. With count==1, always allocate.
- Simultaneous pop and allocate: count unchanged, both pointers advance.
- Simultaneous pop and coalesce with count==2: allowed. The tail (not the in-flight head) is overwritten and becomes the head next cycle.
- Rejected enqueue (`i_enq_vld` && !`o_enq_rdy`): record discarded, `o_drop_cnt`+1, saturating at 0xFFFF.
- `i_update_finished` in IDLE is ignored: no pop, no underflow.
- Reset (also mid-transfer): pointers, count and storage cleared to 0; state IDLE. An in-flight FTB write completes in the FTB, and its finished pulse is ignored.

## Timing
- Reset values: `o_update_req`=0, `o_enq_rdy`=1, `o_update_pc`=0, `o_update_ftbInfo`='0, `o_count`=0, `o_drop_cnt`=0.
- Enqueue into an empty queue at cycle t: `o_update_req`=1 at t+1 (no bypass). The FTB accepts at t+1 and `i_update_finished`=1 at t+2. The entry pops at the end of t+2, and the next head is presented at t+3.
- `o_update_req` stays high continuously while records remain. The FTB ignores it during its updating cycle, so sustained throughput is one update per 2 cycles.
- If the FTB delays acceptance, req and data are held indefinitely with no timeout.

## Structure
- `ftbInfo_t`, `XDEF` and `WDEF` come from the shared frontend header. Add `ftbUpdateRec_t` {pc, ftbInfo} to the same header for reuse by the commit stage.
- The FSM state enum goes in a package `ftbUpdQ_status_t` with values idle and req.
- One sub-module is natural: `ftb_update_fifo` (storage, pointers, count, tail-overwrite port). The top holds the FSM, coalesce compare and drop counter.

## Test plan
- Single record: enq pc=0x1000 at t0 → req=1 with pc=0x1000 at t1; finished at t2 → count=0, req=0 at t3.
- Burst of 4 distinct PCs 0x1000/0x1040/0x1080/0x10C0 with DEPTH=4 and FTB model finishing 1 cycle after accept → issued in order, one every 2 cycles, no drops.
- Coalesce: queue holds {0x2000, 0x2040}, enq 0x2040 with new info → count stays 2, and the second update carries the new info. An enq matching only the in-flight head with count==1 allocates a new entry (count=2).
- Full: 4 entries, no finished, enq 3 more → o_enq_rdy=0 and drop_cnt=3. An enq on a cycle with finished=1 is accepted, count stays 4.
- Stability: during a REQ window, enq with a new pc → o_update_pc/o_update_ftbInfo unchanged through the finished cycle.
- Reset mid-transfer: rst while req=1 and count=3 → next cycle req=0, count=0, drop_cnt=0. A stray finished afterwards causes no pop and count stays 0.
